// File: rtl/ssub_sad_accum.sv
// Sum-of-absolute-differences accumulator behind the signed subtractor.
// Each start runs one accumulation of len samples and returns one saturating SAD result.
module ssub_sad_accum #(
  parameter int DATAWIDTH = 64,
  parameter int ACCWIDTH  = 72,
  parameter int LENWIDTH  = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [LENWIDTH-1:0]  len,
  input  logic [DATAWIDTH-1:0] diff,
  input  logic                 diff_valid,
  output logic                 diff_ready,
  output logic [ACCWIDTH-1:0]  sad,
  output logic                 sad_valid,
  input  logic                 sad_ready,
  output logic                 overflow,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  // Handshakes: a beat transfers on a rising edge where valid && ready; valid is never
  // withdrawn before the transfer, and ready here depends on state only.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  logic [ACCWIDTH-1:0]  acc;
  logic [LENWIDTH-1:0]  remaining;
  logic [DATAWIDTH-1:0] abs_diff;
  logic [ACCWIDTH:0]    sum;
  logic [ACCWIDTH-1:0]  acc_next;

  // Magnitude kept unsigned in DATAWIDTH bits so the most negative input maps exactly.
  assign abs_diff = diff[DATAWIDTH-1] ? (~diff + 1'b1) : diff;
  assign sum      = {1'b0, acc} + {{(ACCWIDTH + 1 - DATAWIDTH){1'b0}}, abs_diff};
  assign acc_next = sum[ACCWIDTH] ? {ACCWIDTH{1'b1}} : sum[ACCWIDTH-1:0];

  assign diff_ready = (state == ACCUM);
  assign sad_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      sad       <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            overflow  <= 1'b0;
            remaining <= len;
            if (len == '0) begin
              sad   <= '0;
              state <= DONE;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (diff_valid) begin
            acc       <= acc_next;
            remaining <= remaining - LENWIDTH'(1);
            if (sum[ACCWIDTH]) overflow <= 1'b1;
            if (remaining == LENWIDTH'(1)) begin
              sad   <= acc_next;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (sad_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssub_sad_accum.sv
// Bench for ssub_sad_accum: directed runs with literal results plus random runs,
// all checked every cycle against a transaction-level SAD model.
module tb_ssub_sad_accum;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int LW = 4;
  localparam int ACC_MAX = (1 << AW) - 1;

  logic          Clk;
  logic          Rst;
  logic          start;
  logic [LW-1:0] len;
  logic [DW-1:0] diff;
  logic          diff_valid;
  logic          diff_ready;
  logic [AW-1:0] sad;
  logic          sad_valid;
  logic          sad_ready;
  logic          overflow;
  logic          busy;
  logic [1:0]    state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  ssub_sad_accum #(.DATAWIDTH(DW), .ACCWIDTH(AW), .LENWIDTH(LW)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .len(len), .diff(diff),
    .diff_valid(diff_valid), .diff_ready(diff_ready), .sad(sad),
    .sad_valid(sad_valid), .sad_ready(sad_ready), .overflow(overflow),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial Clk = 0;
  always #5 Clk = ~Clk;

  // ---------------- behavioural model ----------------
  // Tracks the run as a transaction: whether a run is open, samples still owed,
  // running magnitude sum (plain integer, clipped), and whether a result is pending.
  bit            m_running = 0;
  bit            m_pending = 0;
  int            m_owed    = 0;
  int            m_total   = 0;
  bit            m_ov      = 0;
  int            m_sad     = 0;
  logic [AW-1:0] exp_q[$];

  function automatic int magnitude(input logic [DW-1:0] d);
    int v;
    v = int'($signed(d));
    return (v < 0) ? -v : v;
  endfunction

  always @(posedge Clk) begin
    if (Rst) begin
      m_running = 0; m_pending = 0; m_owed = 0; m_total = 0; m_ov = 0; m_sad = 0;
      exp_q.delete();
    end else if (m_pending) begin
      if (sad_ready) m_pending = 0;
    end else if (m_running) begin
      if (diff_valid) begin
        m_total = m_total + magnitude(diff);
        if (m_total > ACC_MAX) begin
          m_total = ACC_MAX;
          m_ov = 1;
        end
        m_owed--;
        if (m_owed == 0) begin
          m_running = 0;
          m_pending = 1;
          m_sad = m_total;
          exp_q.push_back(AW'(m_sad));
        end
      end
    end else if (start) begin
      m_total = 0; m_ov = 0; m_owed = int'(len);
      if (m_owed == 0) begin
        m_pending = 1;
        m_sad = 0;
        exp_q.push_back('0);
      end else begin
        m_running = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process + scoreboard ----------------
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("diff_ready", 32'(diff_ready), 32'(m_running));
      chk("sad_valid",  32'(sad_valid),  32'(m_pending));
      chk("busy",       32'(busy),       32'(m_running | m_pending));
      chk("overflow",   32'(overflow),   32'(m_ov));
      chk("sad",        32'(sad),        32'(m_sad));
      if (sad_valid && sad_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_result", 32'(sad_valid), 32'd0);
        else chk("sb_result", 32'(sad), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_start(input int l);
    start = 1; len = LW'(l);
    cyc(1);
    start = 0;
  endtask

  task automatic send(input int d, input int gap);
    bit done;
    done = 0;
    diff = DW'(d); diff_valid = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge Clk);
      if (diff_ready) done = 1;
      @(posedge Clk);
      #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    diff_valid = 0;
    diff = $urandom_range(0, 255);
    cyc(gap);
  endtask

  // Waits for the result, pins it to literal values, holds backpressure, then takes it.
  task automatic get_result(input int exp_sad, input int exp_ov, input int hold, input bit lit);
    bit seen;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge Clk);
      if (sad_valid) seen = 1;
    end
    if (!seen) chk("result_timeout", 32'd0, 32'd1);
    if (lit) begin
      chk("lit_sad", 32'(sad), 32'(exp_sad));
      chk("lit_overflow", 32'(overflow), 32'(exp_ov));
    end
    @(posedge Clk); #1;
    cyc(hold);
    sad_ready = 1;
    cyc(1);
    sad_ready = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int l, h;
    Rst = 1; start = 0; len = '0; diff = '0; diff_valid = 0; sad_ready = 0;
    @(posedge Clk); #1;
    chk_en = 1;
    cyc(2);
    Rst = 0;
    chk("reset_sad", 32'(sad), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'd0);

    // Basic: 3 + 5 + 0 + 128
    do_start(4);
    diff_valid = 1;
    send(3, 0); send(-5, 0); send(0, 0); send(-128, 0);
    chk("basic_valid_next_cycle", 32'(sad_valid), 32'd1);
    get_result(136, 0, 0, 1);

    // Gaps and 5 cycles of backpressure
    do_start(3);
    send(10, 2); send(-10, 2); send(7, 0);
    get_result(27, 0, 5, 1);

    // Saturation, then a clean run clears the sticky flag
    do_start(9);
    for (int i = 0; i < 9; i++) send(-128, 0);
    get_result(ACC_MAX, 1, 1, 1);
    do_start(1);
    send(5, 0);
    get_result(5, 0, 0, 1);

    // Zero length: a presented sample must not be taken
    diff = 8'd77; diff_valid = 1;
    do_start(0);
    chk("zero_len_valid", 32'(sad_valid), 32'd1);
    get_result(0, 0, 1, 1);
    diff_valid = 0;

    // Reset mid-run
    do_start(5);
    send(4, 0); send(4, 0);
    Rst = 1;
    cyc(1);
    Rst = 0;
    chk("midreset_sad", 32'(sad), 32'd0);
    chk("midreset_state", 32'(state_dbg), 32'd0);
    chk("midreset_ready", 32'(diff_ready), 32'd0);
    do_start(1);
    send(-1, 0);
    get_result(1, 0, 0, 1);

    // start while busy is ignored
    do_start(2);
    send(6, 0);
    start = 1; len = 4'd9;
    cyc(1);
    start = 0;
    send(-7, 0);
    get_result(13, 0, 0, 1);
    chk("busy_start_ignored", 32'(busy), 32'd0);

    // Random runs, including start held across the DONE->IDLE transfer
    for (int r = 0; r < 25; r++) begin
      l = $urandom_range(0, 15);
      do_start(l);
      for (int s = 0; s < l; s++) begin
        h = $urandom_range(0, 3);
        if ($urandom_range(0, 3) == 0) send(($urandom_range(0, 1) == 0) ? -128 : 127, h);
        else send(int'($urandom_range(0, 255)) - 128, h);
      end
      if ($urandom_range(0, 2) == 0) start = 1;
      get_result(0, 0, $urandom_range(0, 3), 0);
      start = 0;
      cyc(1);
    end

    cyc(2);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
